// File: rtl/inv_mix_columns.sv
// AES InvMixColumns stage with valid/ready handshake, iterating COLS_PER_CYCLE columns per cycle.
// Optional macro INV_MIX_BYPASS_EN adds in_bypass to pass the captured state through unchanged.
module inv_mix_columns #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
`ifdef INV_MIX_BYPASS_EN
   ,input  logic         in_bypass
`endif
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("inv_mix_columns: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE % 4);
    localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

    state_t       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] in_q, in_d;
    logic [127:0] out_q, out_d;
    logic         capture;
`ifdef INV_MIX_BYPASS_EN
    logic         byp_q, byp_d;
`endif

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int unsigned i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            in_q    <= '0;
            out_q   <= '0;
`ifdef INV_MIX_BYPASS_EN
            byp_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            in_q    <= in_d;
            out_q   <= out_d;
`ifdef INV_MIX_BYPASS_EN
            byp_q   <= byp_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        in_d    = in_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = CALC;
                    capture = 1'b1;
                end
            end
            CALC: begin
                cnt_d = cnt_q + STEP;
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                // Handoff and a new capture may share one edge.
                if (out_ready) begin
                    if (in_valid) begin
                        state_d = CALC;
                        capture = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (capture) begin
            in_d  = in_state;
            cnt_d = '0;
        end
    end

`ifdef INV_MIX_BYPASS_EN
    always_comb begin
        byp_d = byp_q;
        if (capture) byp_d = in_bypass;
    end
`endif

    always_comb begin
        logic [1:0]  idx;
        int unsigned pos;
        logic [31:0] col;
        out_d = out_q;
        idx   = '0;
        pos   = 0;
        col   = '0;
        if (state_q == CALC) begin
            for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
                idx = cnt_q + 2'(j);
                pos = 32 * (3 - 32'(idx));
                col = in_q[pos +: 32];
`ifdef INV_MIX_BYPASS_EN
                out_d[pos +: 32] = byp_q ? col : inv_col(col);
`else
                out_d[pos +: 32] = inv_col(col);
`endif
            end
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        out_valid = (state_q == DONE);
        busy      = (state_q == CALC);
        out_state = out_q;
    end

endmodule
